ifetch_unit: RTL and testbench

- Producer side of the instruction-register interface for the multicycle MIPS32 datapath.
- On a controller request, fetches one 32-bit word from instruction memory at the current PC over a req/ack handshake.
- Presents the word on ins with a one-cycle IRWr strobe, then advances the PC by 4 or to a pending redirect target.

---
 rtl/ifetch_pkg.sv | 20 ++
 rtl/ifetch_if.sv | 23 ++
 rtl/ifetch_wdog.sv | 31 +++
 rtl/ifetch_unit.sv | 134 +++++++++++++
 tb/tb_ifetch_unit.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// Shared constants for the instruction fetch unit: state encoding,
// NOP word, reset PC and PC increment.
package ifetch_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_DLVR = 2'd2;

    localparam logic [31:0] INS_NOP      = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] PC_INC       = 32'd4;

    // Force a redirect target onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Instruction memory read bus: req/ack handshake with same-cycle data.
interface ifetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/ifetch_wdog.sv
// Request watchdog: counts cycles while run is high and flags expiry on
// the last allowed cycle so the caller can leave on the following edge.
module ifetch_wdog #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic run,
    input  logic clear,
    output logic expire
);
    import ifetch_pkg::*;

    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] count_reg;

    // Count while waiting; restart whenever the wait ends or is satisfied.
    always_ff @(posedge clk) begin
        if (!clr) begin
            count_reg <= '0;
        end else if (!run || clear) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expire = run && !clear && (count_reg == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit for the multicycle MIPS32 datapath.
// Fetches one word per fetch_go, strobes IRWr for one cycle, then advances
// the PC by 4 or to a pending redirect. Optional request timeout with a
// bus_err pulse is enabled by defining IFETCH_TIMEOUT_EN.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           fetch_go,
    input  logic           pc_wr,
    input  logic [31:0]    pc_in,
    ifetch_if.master       bus,
    output logic [31:0]    ins,
    output logic           IRWr,
    output logic [31:0]    pc,
    output logic [31:0]    pc_plus4,
    output logic           busy,
`ifdef IFETCH_TIMEOUT_EN
    output logic           bus_err,
`endif
    output logic           addr_err
);

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] ins_reg;
    logic        req_reg;
    logic [31:0] addr_reg;
    logic        addr_err_reg;
    logic        pend_valid_reg;
    logic [31:0] pend_reg;
    logic [31:0] target;
    logic        timed_out;

`ifdef IFETCH_TIMEOUT_EN
    logic err_reg;

    ifetch_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
        .clk    (clk),
        .clr    (clr),
        .run    (state_reg == ST_REQ),
        .clear  (bus.imem_ack),
        .expire (timed_out)
    );

    assign bus_err = (state_reg == ST_DLVR) && err_reg;
`else
    assign timed_out = 1'b0;
`endif

    assign target = align_word(pc_in);

    // Fetch sequencer, PC update and redirect bookkeeping.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_reg      <= ST_IDLE;
            pc_reg         <= RESET_PC;
            ins_reg        <= INS_NOP;
            req_reg        <= 1'b0;
            addr_reg       <= '0;
            addr_err_reg   <= 1'b0;
            pend_valid_reg <= 1'b0;
            pend_reg       <= '0;
`ifdef IFETCH_TIMEOUT_EN
            err_reg        <= 1'b0;
`endif
        end else begin
            addr_err_reg <= pc_wr && (pc_in[1:0] != 2'b00);
            case (state_reg)
                ST_IDLE: begin
                    if (pc_wr) begin
                        pc_reg <= target;
                    end
                    if (fetch_go) begin
                        state_reg <= ST_REQ;
                        req_reg   <= 1'b1;
                        addr_reg  <= pc_wr ? target : pc_reg;
                    end
                end
                ST_REQ: begin
                    if (pc_wr) begin
                        pend_valid_reg <= 1'b1;
                        pend_reg       <= target;
                    end
                    if (bus.imem_ack) begin
                        ins_reg   <= bus.imem_rdata;
                        req_reg   <= 1'b0;
                        state_reg <= ST_DLVR;
                    end else if (timed_out) begin
                        ins_reg   <= INS_NOP;
                        req_reg   <= 1'b0;
                        state_reg <= ST_DLVR;
`ifdef IFETCH_TIMEOUT_EN
                        err_reg   <= 1'b1;
`endif
                    end
                end
                ST_DLVR: begin
                    // A redirect arriving in this very cycle is the latest write.
                    if (pc_wr) begin
                        pc_reg <= target;
                    end else if (pend_valid_reg) begin
                        pc_reg <= pend_reg;
                    end else begin
                        pc_reg <= pc_reg + PC_INC;
                    end
                    pend_valid_reg <= 1'b0;
                    state_reg      <= ST_IDLE;
`ifdef IFETCH_TIMEOUT_EN
                    err_reg        <= 1'b0;
`endif
                end
                default: begin
                    state_reg <= ST_IDLE;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req  = req_reg;
    assign bus.imem_addr = addr_reg;
    assign ins           = ins_reg;
    assign IRWr          = (state_reg == ST_DLVR);
    assign pc            = pc_reg;
    assign pc_plus4      = pc_reg + PC_INC;
    assign busy          = (state_reg != ST_IDLE);
    assign addr_err      = addr_err_reg;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed testbench for ifetch_unit; covers IFETCH_TIMEOUT_EN when defined.
module tb_ifetch_unit;

    logic        clk;
    logic        clr;
    logic        fetch_go;
    logic        pc_wr;
    logic [31:0] pc_in;
    logic [31:0] ins;
    logic        IRWr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        busy;
    logic        addr_err;
`ifdef IFETCH_TIMEOUT_EN
    logic        bus_err;
`endif

    int n_cmp;
    int n_bad;

    ifetch_if bus ();

    ifetch_unit dut (
        .clk      (clk),
        .clr      (clr),
        .fetch_go (fetch_go),
        .pc_wr    (pc_wr),
        .pc_in    (pc_in),
        .bus      (bus),
        .ins      (ins),
        .IRWr     (IRWr),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .busy     (busy),
`ifdef IFETCH_TIMEOUT_EN
        .bus_err  (bus_err),
`endif
        .addr_err (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end else begin
            $display("ok   %s: %08h", tag, act);
        end
    endtask

    // Advance one rising edge, then settle before outputs are sampled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b0; fetch_go = 1'b0; pc_wr = 1'b0; pc_in = '0;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        n_cmp = 0; n_bad = 0;

        // Reset state
        step(); step();
        check_val("rst_pc", pc, 32'h0000_3000);
        check_val("rst_ins", ins, 32'h0);
        check_val("rst_irwr", {31'b0, IRWr}, 32'd0);
        check_val("rst_req", {31'b0, bus.imem_req}, 32'd0);
        check_val("rst_addr", bus.imem_addr, 32'h0);
        check_val("rst_aerr", {31'b0, addr_err}, 32'd0);
        check_val("rst_busy", {31'b0, busy}, 32'd0);
        check_val("rst_pc4", pc_plus4, 32'h0000_3004);
        clr = 1'b1;
        step();

        // Basic fetch, ack two cycles after request
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
        check_val("f1_req", {31'b0, bus.imem_req}, 32'd1);
        check_val("f1_addr", bus.imem_addr, 32'h0000_3000);
        check_val("f1_busy", {31'b0, busy}, 32'd1);
        step();
        check_val("f1_hold_req", {31'b0, bus.imem_req}, 32'd1);
        check_val("f1_irwr_wait", {31'b0, IRWr}, 32'd0);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2008_0005;
        step();
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'hFFFF_FFFF;
        check_val("f1_irwr", {31'b0, IRWr}, 32'd1);
        check_val("f1_ins", ins, 32'h2008_0005);
        check_val("f1_pc_dlvr", pc, 32'h0000_3000);
        check_val("f1_req_drop", {31'b0, bus.imem_req}, 32'd0);
        step();
        check_val("f1_irwr_off", {31'b0, IRWr}, 32'd0);
        check_val("f1_pc_next", pc, 32'h0000_3004);
        check_val("f1_idle", {31'b0, busy}, 32'd0);
        check_val("f1_ins_hold", ins, 32'h2008_0005);

        // Same-cycle redirect and fetch in IDLE
        pc_wr = 1'b1; pc_in = 32'h0040_0010; fetch_go = 1'b1;
        step();
        pc_wr = 1'b0; fetch_go = 1'b0;
        check_val("rd_addr", bus.imem_addr, 32'h0040_0010);
        check_val("rd_aerr", {31'b0, addr_err}, 32'd0);
        check_val("rd_pc", pc, 32'h0040_0010);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h8C08_0000;
        step();
        bus.imem_ack = 1'b0;
        check_val("rd_ins", ins, 32'h8C08_0000);
        step();
        check_val("rd_pc_next", pc, 32'h0040_0014);

        // Misaligned redirect during REQ
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
        check_val("mr_addr", bus.imem_addr, 32'h0040_0014);
        pc_wr = 1'b1; pc_in = 32'h0040_0022;
        step();
        pc_wr = 1'b0;
        check_val("mr_aerr", {31'b0, addr_err}, 32'd1);
        check_val("mr_addr_hold", bus.imem_addr, 32'h0040_0014);
        check_val("mr_pc_hold", pc, 32'h0040_0014);
        step();
        check_val("mr_aerr_pulse", {31'b0, addr_err}, 32'd0);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hAAAA_5555;
        step();
        bus.imem_ack = 1'b0;
        check_val("mr_irwr", {31'b0, IRWr}, 32'd1);
        check_val("mr_ins", ins, 32'hAAAA_5555);
        check_val("mr_pc_dlvr", pc, 32'h0040_0014);
        step();
        check_val("mr_pc_next", pc, 32'h0040_0020);

        // Reset in REQ with a late ack
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
        check_val("rr_req", {31'b0, bus.imem_req}, 32'd1);
        clr = 1'b0;
        step();
        clr = 1'b1;
        check_val("rr_req_drop", {31'b0, bus.imem_req}, 32'd0);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        bus.imem_ack = 1'b0;
        check_val("rr_irwr", {31'b0, IRWr}, 32'd0);
        check_val("rr_ins", ins, 32'h0);
        check_val("rr_pc", pc, 32'h0000_3000);
        check_val("rr_busy", {31'b0, busy}, 32'd0);

        // PC wrap at top of address space
        pc_wr = 1'b1; pc_in = 32'hFFFF_FFFC; fetch_go = 1'b1;
        step();
        pc_wr = 1'b0; fetch_go = 1'b0;
        check_val("wr_addr", bus.imem_addr, 32'hFFFF_FFFC);
        check_val("wr_pc4", pc_plus4, 32'h0000_0000);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678;
        step();
        bus.imem_ack = 1'b0;
        check_val("wr_ins", ins, 32'h1234_5678);
        step();
        check_val("wr_pc", pc, 32'h0000_0000);

        // No ack: timeout build delivers a NOP, default build keeps waiting
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
        for (int i = 0; i < 15; i++) step();
        check_val("to_pre_irwr", {31'b0, IRWr}, 32'd0);
        check_val("to_pre_req", {31'b0, bus.imem_req}, 32'd1);
        step();
        check_val("to_irwr", {31'b0, IRWr}, 32'd1);
        check_val("to_buserr", {31'b0, bus_err}, 32'd1);
        check_val("to_ins", ins, 32'h0);
        check_val("to_req", {31'b0, bus.imem_req}, 32'd0);
        step();
        check_val("to_idle", {31'b0, busy}, 32'd0);
        check_val("to_buserr_off", {31'b0, bus_err}, 32'd0);
        check_val("to_pc", pc, 32'h0000_0004);
`else
        for (int i = 0; i < 20; i++) step();
        check_val("nw_req", {31'b0, bus.imem_req}, 32'd1);
        check_val("nw_irwr", {31'b0, IRWr}, 32'd0);
        check_val("nw_ins", ins, 32'h1234_5678);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_000C;
        step();
        bus.imem_ack = 1'b0;
        check_val("nw_dlvr", ins, 32'h0000_000C);
        step();
        check_val("nw_pc", pc, 32'h0000_0004);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
